// File: rtl/apb_regfile_slave.sv
// APB completer register bank with programmable wait states, byte strobes and error decode.
// Optional write protection of high registers: define APB_REGFILE_PROT_CHECK_EN.
module apb_regfile_slave #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    NUM_REGS    = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_STATES = 1,
  parameter int                    PRIV_BASE   = 8
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic                    psel,
  input  logic                    penable,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [2:0]              pprot,
  input  logic                    pwrite,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic                    pready,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pslverr
);

  localparam int LP_BYTES = DATA_WIDTH / 8;
  localparam int LP_LSB   = $clog2(LP_BYTES);
  localparam int LP_IDXW  = $clog2(NUM_REGS);
  localparam int LP_TOP   = LP_LSB + LP_IDXW;

  localparam logic [3:0] LP_WAIT = 4'(WAIT_STATES);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  logic [0:0]            r_state;
  logic [0:0]            w_state_next;
  logic [3:0]            r_cnt;
  logic [3:0]            w_cnt_next;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  logic [ADDR_WIDTH-1:0] w_off;
  logic [LP_IDXW-1:0]    w_idx;
  logic                  w_err_range;
  logic                  w_err_align;
  logic                  w_err_prot;
  logic                  w_err;
  logic                  w_complete;
  logic                  w_wr_en;
  logic [DATA_WIDTH-1:0] w_cur_word;
  logic [DATA_WIDTH-1:0] w_wr_word;
  logic                  w_unused;

  // Wrap-around subtraction folds addresses below BASE_ADDR into the range error.
  assign w_off       = paddr - BASE_ADDR;
  assign w_idx       = w_off[LP_TOP-1:LP_LSB];
  assign w_err_range = |w_off[ADDR_WIDTH-1:LP_TOP];

  generate
    if (LP_LSB > 0) begin : g_align
      assign w_err_align = |w_off[LP_LSB-1:0];
    end else begin : g_no_align
      assign w_err_align = 1'b0;
    end
  endgenerate

`ifdef APB_REGFILE_PROT_CHECK_EN
  localparam logic [LP_IDXW:0] LP_PRIV = (LP_IDXW + 1)'(PRIV_BASE);
  assign w_err_prot = pwrite & ~pprot[0] & ({1'b0, w_idx} >= LP_PRIV);
`else
  assign w_err_prot = 1'b0;
`endif

  assign w_unused = &{1'b0, pprot};

  assign w_err      = w_err_range | w_err_align | w_err_prot;
  assign w_complete = presetn & (r_state == ST_ACCESS) & psel & penable & (r_cnt == 4'd0);
  assign w_wr_en    = w_complete & pwrite & ~w_err;

  assign pready  = w_complete;
  assign pslverr = w_complete & w_err;
  assign prdata  = (w_complete & ~pwrite & ~w_err) ? r_regs[w_idx] : '0;

  assign w_cur_word = r_regs[w_idx];

  generate
    for (genvar gi = 0; gi < LP_BYTES; gi++) begin : g_lane
      assign w_wr_word[gi*8 +: 8] = pstrb[gi] ? pwdata[gi*8 +: 8] : w_cur_word[gi*8 +: 8];
    end
  endgenerate

  // A missing setup phase still passes through IDLE first, costing one extra cycle.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (psel) begin
          w_state_next = ST_ACCESS;
          w_cnt_next   = LP_WAIT;
        end
      end
      ST_ACCESS: begin
        if (!psel) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = 4'd0;
        end else if (penable) begin
          if (r_cnt == 4'd0) begin
            w_state_next = ST_IDLE;
          end else begin
            w_cnt_next = r_cnt - 4'd1;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[w_idx] <= w_wr_word;
    end
  end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Directed bench for apb_regfile_slave: a 2-wait-state instance driven from a vector table,
// plus a zero-wait instance for back-to-back transfers and hand-written corner sequences.
module tb_apb_regfile_slave;

  logic        pclk;
  logic        presetn;
  logic        psel_a;
  logic        psel_b;
  logic        penable;
  logic [31:0] paddr;
  logic [2:0]  pprot;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready_a;
  logic        pready_b;
  logic [31:0] prdata_a;
  logic [31:0] prdata_b;
  logic        pslverr_a;
  logic        pslverr_b;

  int checks   = 0;
  int failures = 0;

  apb_regfile_slave #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .NUM_REGS   (16),
    .BASE_ADDR  (32'h0),
    .WAIT_STATES(2),
    .PRIV_BASE  (8)
  ) dut_a (
    .pclk   (pclk),
    .presetn(presetn),
    .psel   (psel_a),
    .penable(penable),
    .paddr  (paddr),
    .pprot  (pprot),
    .pwrite (pwrite),
    .pwdata (pwdata),
    .pstrb  (pstrb),
    .pready (pready_a),
    .prdata (prdata_a),
    .pslverr(pslverr_a)
  );

  apb_regfile_slave #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .NUM_REGS   (16),
    .BASE_ADDR  (32'h0),
    .WAIT_STATES(0),
    .PRIV_BASE  (8)
  ) dut_b (
    .pclk   (pclk),
    .presetn(presetn),
    .psel   (psel_b),
    .penable(penable),
    .paddr  (paddr),
    .pprot  (pprot),
    .pwrite (pwrite),
    .pwdata (pwdata),
    .pstrb  (pstrb),
    .pready (pready_b),
    .prdata (prdata_b),
    .pslverr(pslverr_b)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] strb, input logic [2:0] prot,
                              input logic [31:0] exp_rdata, input bit exp_err);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb; v.prot = prot;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    @(negedge pclk);
    psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  // One APB transfer; cyc counts cycles with penable high up to and including completion (-1 on timeout).
  task automatic xfer(input bit tgt, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] strb, input logic [2:0] prot, input bit nosetup,
                      output logic [31:0] rd, output logic err, output logic setup_rdy,
                      output int cyc);
    bit done;
    rd = '0; err = 1'b0; setup_rdy = 1'b0; cyc = 0; done = 1'b0;
    @(negedge pclk);
    paddr = addr; pwdata = wd; pstrb = strb; pprot = prot; pwrite = wr;
    psel_a = !tgt; psel_b = tgt;
    penable = nosetup;
    if (!nosetup) begin
      #1;
      setup_rdy = tgt ? pready_b : pready_a;
      @(negedge pclk);
      penable = 1'b1;
    end
    while (!done && cyc < 20) begin
      #1;
      cyc++;
      if (tgt ? pready_b : pready_a) begin
        done = 1'b1;
        rd   = tgt ? prdata_b : prdata_a;
        err  = tgt ? pslverr_b : pslverr_a;
      end else begin
        @(negedge pclk);
      end
    end
    if (!done) cyc = -1;
    $display("xfer dut=%s %s addr=%h wdata=%h strb=%h prot=%0d -> rdata=%h err=%0b cycles=%0d",
             tgt ? "B" : "A", wr ? "WR" : "RD", addr, wd, strb, prot, rd, err, cyc);
  endtask

  logic [31:0] rd;
  logic        err;
  logic        srdy;
  int          cyc;
  logic [31:0] exp_regs [16];

  initial begin
    presetn = 1'b0; psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
    paddr = 32'h3C; pprot = 3'b000; pwrite = 1'b0; pwdata = '0; pstrb = '0;

    // Reset with a read presented to both instances: outputs must stay quiet.
    @(negedge pclk);
    psel_a = 1'b1; psel_b = 1'b1; penable = 1'b1;
    @(negedge pclk);
    #1;
    chk("rst_pready_a", {31'd0, pready_a}, 32'd0);
    chk("rst_pslverr_a", {31'd0, pslverr_a}, 32'd0);
    chk("rst_prdata_a", prdata_a, 32'd0);
    chk("rst_pready_b", {31'd0, pready_b}, 32'd0);
    bus_idle();
    presetn = 1'b1;

    add(0, 32'h3C, 32'h0, 4'h0, 3'b000, 32'h00000000, 0);
    add(1, 32'h08, 32'hDEADBEEF, 4'hF, 3'b000, 32'h0, 0);
    add(0, 32'h08, 32'h0, 4'h0, 3'b000, 32'hDEADBEEF, 0);
    add(1, 32'h08, 32'h11223344, 4'h5, 3'b000, 32'h0, 0);
    add(0, 32'h08, 32'h0, 4'h0, 3'b000, 32'hDE22BE44, 0);
    add(1, 32'h40, 32'hFFFFFFFF, 4'hF, 3'b000, 32'h0, 1);
    add(1, 32'h06, 32'hFFFFFFFF, 4'hF, 3'b000, 32'h0, 1);
    add(1, 32'hFFFFFFFC, 32'hFFFFFFFF, 4'hF, 3'b000, 32'h0, 1);
    add(0, 32'h40, 32'h0, 4'h0, 3'b000, 32'h0, 1);
    add(0, 32'h0A, 32'h0, 4'hF, 3'b000, 32'h0, 1);
    add(1, 32'h10, 32'hAABBCCDD, 4'hF, 3'b000, 32'h0, 0);
    add(1, 32'h0C, 32'h99999999, 4'h0, 3'b000, 32'h0, 0);
    add(0, 32'h0C, 32'h0, 4'h0, 3'b000, 32'h00000000, 0);
    add(1, 32'h3C, 32'h12345678, 4'hA, 3'b000, 32'h0, 0);
    add(0, 32'h3C, 32'h0, 4'h0, 3'b000, 32'h12005600, 0);
    add(1, 32'h1C, 32'h0000BEEF, 4'h3, 3'b000, 32'h0, 0);
    add(0, 32'h1C, 32'h0, 4'h0, 3'b000, 32'h0000BEEF, 0);
`ifdef APB_REGFILE_PROT_CHECK_EN
    add(1, 32'h20, 32'hCAFEF00D, 4'hF, 3'b000, 32'h0, 1);
    add(0, 32'h20, 32'h0, 4'h0, 3'b000, 32'h00000000, 0);
`endif
    add(1, 32'h20, 32'hCAFEF00D, 4'hF, 3'b001, 32'h0, 0);
    add(0, 32'h20, 32'h0, 4'h0, 3'b000, 32'hCAFEF00D, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      xfer(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].prot, 0,
           rd, err, srdy, cyc);
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("v%0d_pslverr", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
      chk($sformatf("v%0d_cycles", i), 32'(cyc), 32'd3);
      chk($sformatf("v%0d_setup_rdy", i), {31'd0, srdy}, 32'd0);
    end

    // Full readback: errored writes must have left every register untouched.
    for (int i = 0; i < 16; i++) exp_regs[i] = 32'h0;
    exp_regs[2]  = 32'hDE22BE44;
    exp_regs[4]  = 32'hAABBCCDD;
    exp_regs[7]  = 32'h0000BEEF;
    exp_regs[8]  = 32'hCAFEF00D;
    exp_regs[15] = 32'h12005600;
    for (int i = 0; i < 16; i++) begin
      xfer(0, 0, 32'(i * 4), 32'h0, 4'h0, 3'b000, 0, rd, err, srdy, cyc);
      chk($sformatf("rb%0d_rdata", i), rd, exp_regs[i]);
      chk($sformatf("rb%0d_pslverr", i), {31'd0, err}, 32'd0);
    end

    // Missing setup phase: tolerated, one extra cycle.
    bus_idle();
    xfer(0, 0, 32'h08, 32'h0, 4'h0, 3'b000, 1, rd, err, srdy, cyc);
    chk("nosetup_rdata", rd, 32'hDE22BE44);
    chk("nosetup_cycles", 32'(cyc), 32'd4);

    // Abort: psel dropped after one access cycle of a write to 0x10.
    bus_idle();
    @(negedge pclk);
    paddr = 32'h10; pwdata = 32'h55555555; pstrb = 4'hF; pwrite = 1'b1; pprot = 3'b000;
    psel_a = 1'b1; penable = 1'b0;
    @(negedge pclk);
    penable = 1'b1;
    #1;
    chk("abort_acc1_pready", {31'd0, pready_a}, 32'd0);
    @(negedge pclk);
    psel_a = 1'b0; penable = 1'b0;
    #1;
    chk("abort_drop_pready", {31'd0, pready_a}, 32'd0);
    xfer(0, 0, 32'h10, 32'h0, 4'h0, 3'b000, 0, rd, err, srdy, cyc);
    chk("abort_rdata", rd, 32'hAABBCCDD);
    chk("abort_cycles", 32'(cyc), 32'd3);

    // Reset arriving in the completion cycle of a write: no response, no write.
    bus_idle();
    @(negedge pclk);
    paddr = 32'h08; pwdata = 32'hFFFFFFFF; pstrb = 4'hF; pwrite = 1'b1;
    psel_a = 1'b1; penable = 1'b0;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    @(negedge pclk);
    presetn = 1'b0;
    #1;
    chk("midrst_pready", {31'd0, pready_a}, 32'd0);
    chk("midrst_pslverr", {31'd0, pslverr_a}, 32'd0);
    bus_idle();
    @(negedge pclk);
    presetn = 1'b1;
    for (int i = 0; i < 16; i++) begin
      xfer(0, 0, 32'(i * 4), 32'h0, 4'h0, 3'b000, 0, rd, err, srdy, cyc);
      chk($sformatf("postrst%0d_rdata", i), rd, 32'h0);
    end

    // Zero-wait instance: four back-to-back writes, then readback.
    bus_idle();
    for (int i = 0; i < 4; i++) begin
      xfer(1, 1, 32'(i * 4), 32'hA5000000 + 32'(i * 32'h00010101), 4'hF, 3'b000, 0,
           rd, err, srdy, cyc);
      chk($sformatf("zw_wr%0d_cycles", i), 32'(cyc), 32'd1);
      chk($sformatf("zw_wr%0d_setup_rdy", i), {31'd0, srdy}, 32'd0);
      chk($sformatf("zw_wr%0d_pslverr", i), {31'd0, err}, 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      xfer(1, 0, 32'(i * 4), 32'h0, 4'h0, 3'b000, 0, rd, err, srdy, cyc);
      chk($sformatf("zw_rd%0d_rdata", i), rd, 32'hA5000000 + 32'(i * 32'h00010101));
      chk($sformatf("zw_rd%0d_cycles", i), 32'(cyc), 32'd1);
    end
    bus_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_regfile_slave.md
Name: apb_regfile_slave

Overview:
- APB completer (slave) register bank that sits directly downstream of the APB bridge; one instance per bridge select line.
- Decodes the bridge's transfer, inserts a programmable number of wait states via pready, and performs byte-strobed writes and word reads on NUM_REGS registers.
- Flags bad transfers on pslverr: out-of-range address, misaligned address and, optionally, protection violations.

Parameters:
- DATA_WIDTH, 32, width of pwdata/prdata; must be a multiple of 8.
- ADDR_WIDTH, 32, width of paddr.
- NUM_REGS, 16, number of DATA_WIDTH registers; power of two, at least 2.
- BASE_ADDR, 0, byte address of register 0.
- WAIT_STATES, 1, access-phase cycles with pready low before completion; 0 to 15.
- PRIV_BASE, 8, first register index protected by the optional feature.

Ports:
- pclk  input  1  clock; all logic on the rising edge.
- presetn  input  1  reset, synchronous, active-low.
- psel  input  1  select from the bridge.
- penable  input  1  access-phase indicator.
- paddr  input  ADDR_WIDTH  byte address.
- pprot  input  3  protection attributes; bit 0 set means privileged.
- pwrite  input  1  1 = write, 0 = read.
- pwdata  input  DATA_WIDTH  write data.
- pstrb  input  DATA_WIDTH/8  write byte strobes.
- pready  output  1  transfer complete.
- prdata  output  DATA_WIDTH  read data.
- pslverr  output  1  transfer error; valid only while pready is high.

Behaviour:
- Reset: on a rising pclk edge with presetn low, the state goes to IDLE, the wait counter to 0 and all registers to 0. While in reset, pready, pslverr and prdata are 0. Reset mid-transfer abandons the transfer with no write.
- FSM states: IDLE, ACCESS.
  - IDLE, psel=1: go to ACCESS and load cnt=WAIT_STATES. A setup phase (penable=0) is the normal entry. A missing setup (penable=1 in IDLE) is tolerated, treated the same, and adds one cycle.
  - ACCESS, psel=0: abort. Go to IDLE with no write and no response.
  - ACCESS, psel=1, penable=1, cnt>0: decrement cnt; pready stays 0.
  - ACCESS, psel=1, penable=1, cnt==0: completion cycle. Go to IDLE.
- Latency: pready=1 in the (WAIT_STATES+1)th access-phase cycle. WAIT_STATES=0 gives a zero-wait transfer.
- Outputs: pready, pslverr and prdata are combinational from state, cnt and the inputs. They are nonzero only in the completion cycle.
- Decode: off = paddr - BASE_ADDR (ADDR_WIDTH wrap-around arithmetic); idx = off / (DATA_WIDTH/8).
  - err_range = off >= NUM_REGS*(DATA_WIDTH/8), including the negative wrap when paddr < BASE_ADDR.
  - err_align = low log2(DATA_WIDTH/8) bits of off are nonzero.
  - err = err_range | err_align (plus the optional protection term).
- Write: at the end of the completion cycle, if pwrite=1 and err=0, update byte lane b of reg[idx] from pwdata lane b for each pstrb[b]=1. pstrb=0 completes OKAY with no change.
- Read: prdata = reg[idx] in the completion cycle when pwrite=0 and err=0, otherwise 0. pstrb is ignored on reads.
- Error: pslverr = err in the completion cycle. An errored write changes no register; an errored read returns 0.
- Back-to-back: a new setup phase in the cycle after completion is accepted from IDLE, so there are no dead cycles beyond the APB setup phase.

Optional Feature:
- Macro APB_REGFILE_PROT_CHECK_EN.
- Defined: a write with pprot[0]=0 to idx >= PRIV_BASE sets err, so pslverr=1 and no register is written. Reads are always allowed.
- Not defined: pprot is ignored.

Test Plan:
- Setup WAIT_STATES=2, BASE_ADDR=0, NUM_REGS=16, DATA_WIDTH=32 unless stated.
- Reset: hold presetn=0 for 2 cycles, release, then read paddr=0x3C -> prdata=0x00000000, pslverr=0, pready high on the 3rd access cycle.
- Write then read: write paddr=0x08, pwdata=0xDEADBEEF, pstrb=0xF, then read 0x08 -> 0xDEADBEEF. Then write pwdata=0x11223344, pstrb=0x5, read 0x08 -> 0xDE22BE44.
- Errors: write paddr=0x40 (range) and paddr=0x06 (misaligned) -> pready with pslverr=1; all 16 registers unchanged on readback. Read 0x40 -> prdata=0, pslverr=1.
- Abort: drop psel after 1 access cycle of a write to 0x10 -> no pready; a subsequent read of 0x10 returns its prior value. Assert presetn=0 mid-write -> all registers read 0 afterwards.
- Zero wait and back-to-back (WAIT_STATES=0): 4 consecutive writes to 0x00..0x0C -> each completes in its first access cycle with no idle cycles between transfers; readback matches.
- Protection (APB_REGFILE_PROT_CHECK_EN): write idx 8 (paddr=0x20) with pprot=3'b000 -> pslverr=1, register unchanged; repeat with pprot=3'b001 -> OKAY, value written; read with pprot=3'b000 -> OKAY.
